// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the off-chip data memory model and the
//               data-cache controller that talks to it: transaction states,
//               default geometry/latency and the line-index address slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  // Default geometry: 512 lines of 256 bits (16 KB), 10-edge access latency.
  localparam int DMEM_DEPTH   = 512;
  localparam int DMEM_WIDTH   = 256;
  localparam int DMEM_LATENCY = 10;

  // Line index inside the byte address; bits below IDX_LSB select a byte
  // within the line and are ignored by the memory.
  localparam int IDX_LSB = 5;
  localparam int IDX_MSB = 13;

  // Wait counter width; LATENCY never exceeds 15 so the counter cannot wrap.
  localparam int CNT_W = 4;

  // Transaction states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_e;

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/dmem_latency_ctrl.sv
// ============================================================================
// Module      : dmem_latency_ctrl
// Description : Request sequencer for the data memory. Accepts a request in
//               IDLE, waits LATENCY edges, then raises a registered one-cycle
//               acknowledge. commit_o marks the ACK cycle so the owner of the
//               array can commit a write on the edge that leaves ACK.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_latency_ctrl
  import dmem_pkg::*;
#(
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic clk_i,
  input  logic rst_i,     // asynchronous, active-low
  input  logic start_i,   // request valid, only looked at in IDLE
  output logic ack_o,     // one-cycle completion pulse, registered
  output logic commit_o   // high for the whole ACK cycle
);

  // Value the counter holds at the edge that moves WAIT to ACK.
  localparam logic [CNT_W-1:0] c_last = CNT_W'(LATENCY - 1);

  dmem_state_e      r_state;
  dmem_state_e      w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_ack;

  // State, wait counter and acknowledge registers; reset aborts any transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_count <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == ACK);
      if (r_state == WAIT) begin
        r_count <= r_count + 1'b1;
      end else begin
        r_count <= '0;
      end
    end
  end

  // Next-state decode; a dropped request during WAIT still runs to completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_next = WAIT;
      WAIT:    if (r_count == c_last) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs: ack straight from its register, commit window decoded from state.
  always_comb begin
    ack_o    = r_ack;
    commit_o = (r_state == ACK);
  end

endmodule : dmem_latency_ctrl

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// Module      : data_memory
// Description : Off-chip main-memory model behind the data cache. Whole-line
//               (256-bit) reads and writes with a fixed multi-cycle latency
//               and a one-cycle acknowledge. The array is not reset so its
//               contents survive reset and can be preloaded by hierarchy.
//               Optional macro DMEM_ADDR_CHECK_EN: requests with
//               addr_i[31:14] != 0 still ack, but do not write and read zero.
//               Without it, upper address bits alias modulo 16 KB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int WIDTH   = DMEM_WIDTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic             clk_i,
  input  logic             rst_i,     // asynchronous, active-low
  input  logic [31:0]      addr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             enable_i,
  input  logic             write_i,
  output logic             ack_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH);

  // Line storage; deliberately without reset.
  logic [WIDTH-1:0] memory [DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic             w_commit;
  logic             w_unused_addr;

  assign w_idx = addr_i[IDX_MSB:IDX_LSB];

`ifdef DMEM_ADDR_CHECK_EN
  assign w_in_range    = (addr_i[31:IDX_MSB+1] == '0);
  assign w_unused_addr = ^addr_i[IDX_LSB-1:0];
`else
  assign w_in_range    = 1'b1;
  assign w_unused_addr = ^{addr_i[31:IDX_MSB+1], addr_i[IDX_LSB-1:0]};
`endif

  dmem_latency_ctrl #(
    .LATENCY (LATENCY)
  ) u_ctrl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (enable_i),
    .ack_o    (ack_o),
    .commit_o (w_commit)
  );

  // Write commits on the edge leaving ACK; this is the only array update.
  always_ff @(posedge clk_i) begin
    if (w_commit && write_i && w_in_range) begin
      memory[w_idx] <= data_i;
    end
  end

  // Combinational line read; a same-line write in ACK is seen only afterwards.
  always_comb begin
    data_o = '0;
    if (w_in_range) begin
      data_o = memory[w_idx];
    end
  end

endmodule : data_memory

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
// Module      : tb_data_memory
// Description : Self-checking bench for data_memory: directed transaction
//               table plus hand sequences for write commit timing,
//               back-to-back requests, reset abort and address aliasing /
//               range checking (DMEM_ADDR_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory;

  localparam logic [255:0] P0 =
    256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] PA5 = {32{8'hA5}};
  localparam logic [255:0] PC3 = {32{8'hC3}};
  localparam logic [255:0] P3C = {32{8'h3C}};

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic [255:0] data_i = '0;
  logic         enable_i = 1'b0;
  logic         write_i = 1'b0;
  logic         ack_o;
  logic [255:0] data_o;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic         hold;
    logic [255:0] wdata;
    logic [255:0] exp;
  } vec_t;

  vec_t tbl [6];

  data_memory dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  function automatic logic [255:0] pat(input int i);
    return {8{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated transaction: returns ack latency in edges after acceptance
  // (-1 on timeout) and data_o sampled in the ack cycle; checks ack falls.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [255:0] d,
                         input logic hold, output int lat, output logic [255:0] rd);
    @(negedge clk_i);
    addr_i = a; write_i = w; data_i = d; enable_i = 1'b1;
    @(posedge clk_i);
    #1;
    if (!hold) enable_i = 1'b0;
    lat = -1;
    rd  = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i);
      #1;
      if (ack_o) begin
        lat = k;
        rd  = data_o;
        break;
      end
    end
    enable_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("ack_one_cycle", 256'(ack_o), 256'(0));
  endtask

  initial begin : main
    int           lat;
    int           t1;
    int           t2;
    logic [255:0] rd;
    logic         flag;

    for (int i = 0; i < 512; i++) dut.memory[i] = pat(i);
    dut.memory[0] = P0;

    tbl[0] = '{32'h0000_0000, 1'b0, 1'b1, '0,  P0};
    tbl[1] = '{32'h0000_0400, 1'b0, 1'b1, '0,  PA5};
    tbl[2] = '{32'h0000_0060, 1'b0, 1'b0, '0,  pat(3)};
    tbl[3] = '{32'h0000_0800, 1'b1, 1'b1, P3C, pat(64)};
    tbl[4] = '{32'h0000_0800, 1'b0, 1'b1, '0,  P3C};
    tbl[5] = '{32'h0000_003F, 1'b0, 1'b1, '0,  pat(1)};

    // Reset state: ack low while reset is held, even before any clock edge.
    #1;
    chk("reset_ack", 256'(ack_o), 256'(0));
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("idle_ack", 256'(ack_o), 256'(0));

    // Write 0x0400: array unchanged until the edge leaving ACK.
    @(negedge clk_i);
    addr_i = 32'h0000_0400; write_i = 1'b1; data_i = PA5; enable_i = 1'b1;
    @(posedge clk_i);
    lat = -1; rd = '0; flag = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i); #1;
      if (dut.memory[32] !== pat(32)) flag = 1'b1;
      if (ack_o) begin lat = k; rd = data_o; break; end
    end
    enable_i = 1'b0;
    chk("wr_latency", 256'(lat), 256'(10));
    chk("wr_early_commit", 256'(flag), 256'(0));
    chk("wr_rdw_old", rd, pat(32));
    @(posedge clk_i); #1;
    chk("wr_ack_fall", 256'(ack_o), 256'(0));
    chk("wr_mem32", dut.memory[32], PA5);
    chk("wr_mem33", dut.memory[33], pat(33));

    // Table-driven transactions.
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].hold, lat, rd);
      chk($sformatf("tbl%0d_latency", i), 256'(lat), 256'(10));
      chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp);
    end

    // Back-to-back reads with enable held: acks 12 edges apart.
    @(negedge clk_i);
    addr_i = 32'h0000_0020; write_i = 1'b0; enable_i = 1'b1;
    t1 = -1; t2 = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_i); #1;
      if (ack_o) begin t1 = edge_cnt; rd = data_o; break; end
    end
    chk("b2b_first_data", rd, pat(1));
    addr_i = 32'h0000_0040;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_i); #1;
      if (ack_o) begin t2 = edge_cnt; rd = data_o; break; end
    end
    enable_i = 1'b0;
    chk("b2b_second_data", rd, pat(2));
    chk("b2b_spacing", 256'(t2 - t1), 256'(12));
    repeat (2) @(posedge clk_i);

    // Reset at WAIT count=5 of a write to 0x0200 aborts it.
    @(negedge clk_i);
    addr_i = 32'h0000_0200; write_i = 1'b1; data_i = PC3; enable_i = 1'b1;
    @(posedge clk_i);
    repeat (5) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("abort_ack_async", 256'(ack_o), 256'(0));
    repeat (2) @(negedge clk_i);
    enable_i = 1'b0; write_i = 1'b0;
    rst_i = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk_i); #1;
      if (ack_o) flag = 1'b1;
    end
    chk("abort_no_ack", 256'(flag), 256'(0));
    chk("abort_mem16", dut.memory[16], pat(16));
    run_txn(32'h0000_0200, 1'b0, '0, 1'b1, lat, rd);
    chk("post_abort_latency", 256'(lat), 256'(10));
    chk("post_abort_data", rd, pat(16));

    // Out-of-range write to 0x4000.
    run_txn(32'h0000_4000, 1'b1, PC3, 1'b1, lat, rd);
    chk("oor_latency", 256'(lat), 256'(10));
`ifdef DMEM_ADDR_CHECK_EN
    chk("oor_data", rd, '0);
    chk("oor_mem0", dut.memory[0], P0);
`else
    chk("alias_data", rd, P0);
    chk("alias_mem0", dut.memory[0], PC3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_data_memory

`default_nettype wire
